// File: rtl/aes_engine.sv
// Iterative AES-128/192/256 forward cipher: one round per clock, with the key
// schedule expanded combinationally from the captured key.
module aes_engine #(
  parameter int KEY_WIDTH = 128,
  parameter int NR        = 10,
  parameter int NK        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [127:0]         data_in,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [127:0]         data_out,
  output logic                 done,
  output logic                 busy
);

  localparam int NW = 4 * (NR + 1);
  localparam int RW = $clog2(NR + 1);
  localparam int IW = $clog2(NW);

  typedef enum logic {IDLE, RUN} fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [RW-1:0]        round_q, round_d;
  logic [127:0]         block_q, block_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [127:0]         dout_q, dout_d;
  logic                 done_q, done_d;

  logic [31:0]   w [NW];
  logic [31:0]   ksTemp;
  logic [IW-1:0] rkBase;
  logic [127:0]  roundKey;
  logic [127:0]  shifted;
  logic [127:0]  roundOut;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse as x^254 (product of x^2..x^128), which maps 0 to 0, then the affine step.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] inv;
    p   = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  function automatic logic [31:0] rcon(input int j);
    logic [7:0] rc;
    rc = 8'h01;
    for (int n = 1; n < 11; n++) begin
      if (n < j) rc = xtime(rc);
    end
    return {rc, 24'h000000};
  endfunction

  function automatic logic [127:0] shiftSub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mixCol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mixCol(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  // Full expansion from key_q; NK=8 gets the extra SubWord at i mod NK == 4.
  always_comb begin
    ksTemp = '0;
    for (int i = 0; i < NK; i++) begin
      w[i] = key_q[KEY_WIDTH-1-32*i -: 32];
    end
    for (int i = NK; i < NW; i++) begin
      ksTemp = w[i-1];
      if (i % NK == 0) begin
        ksTemp = subWord({ksTemp[23:0], ksTemp[31:24]}) ^ rcon(i / NK);
      end else if (NK > 6 && i % NK == 4) begin
        ksTemp = subWord(ksTemp);
      end
      w[i] = w[i-NK] ^ ksTemp;
    end
  end

  always_comb begin
    rkBase   = IW'({round_q, 2'b00});
    roundKey = {w[rkBase], w[rkBase + IW'(1)], w[rkBase + IW'(2)], w[rkBase + IW'(3)]};
    shifted  = shiftSub(block_q);
    if (round_q == '0) begin
      roundOut = block_q ^ roundKey;
    end else if (round_q == RW'(NR)) begin
      roundOut = shifted ^ roundKey;
    end else begin
      roundOut = mixColumns(shifted) ^ roundKey;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      round_q <= '0;
      block_q <= '0;
      key_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      block_q <= block_d;
      key_q   <= key_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    block_d = block_q;
    key_d   = key_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          block_d = data_in;
          key_d   = key;
          round_d = '0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        block_d = roundOut;
        round_d = round_q + RW'(1);
        if (round_q == RW'(NR)) begin
          dout_d  = roundOut;
          done_d  = 1'b1;
          round_d = '0;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (fsm_q == RUN);
    done     = done_q;
    data_out = dout_q;
  end

endmodule

// File: tb/tb_aes_engine.sv
// Directed FIPS-197 vectors for all three key sizes, plus busy, held-start
// and mid-operation reset behaviour.
module tb_aes_engine;

  logic         clk;
  logic         rst_n;
  logic         start0, start1, start2;
  logic [127:0] dataIn;
  logic [127:0] key0;
  logic [191:0] key1;
  logic [255:0] key2;
  logic [127:0] dout0, dout1, dout2;
  logic         done0, done1, done2;
  logic         busy0, busy1, busy2;

  int checks;
  int errors;

  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [191:0] KEY_C = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CT_C  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [255:0] KEY_D = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_D  = 128'h8ea2b7ca516745bfeafc49904b496089;

  aes_engine #(.KEY_WIDTH(128), .NR(10), .NK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .data_in(dataIn), .key(key0),
    .data_out(dout0), .done(done0), .busy(busy0));

  aes_engine #(.KEY_WIDTH(192), .NR(12), .NK(6)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .data_in(dataIn), .key(key1),
    .data_out(dout1), .done(done1), .busy(busy1));

  aes_engine #(.KEY_WIDTH(256), .NR(14), .NK(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .data_in(dataIn), .key(key2),
    .data_out(dout2), .done(done2), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic getDone(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  function automatic logic getBusy(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction

  function automatic logic [127:0] getOut(input int sel);
    return (sel == 0) ? dout0 : (sel == 1) ? dout1 : dout2;
  endfunction

  // Call just after a falling edge; start is seen on the next rising edge.
  task automatic applyStimulus(input int sel, input logic [255:0] k, input logic [127:0] pt,
                               input logic [127:0] exp, input int lat, input string tag);
    int n;
    logic seen;
    dataIn = pt;
    case (sel)
      0: begin key0 = k[255:128]; start0 = 1'b1; end
      1: begin key1 = k[255:64];  start1 = 1'b1; end
      default: begin key2 = k; start2 = 1'b1; end
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    checkOutput({tag, " busy after accept"}, 128'(getBusy(sel)), 128'd1);
    n = 0;
    seen = 1'b0;
    while (n < lat + 5 && !seen) begin
      @(negedge clk);
      n++;
      seen = getDone(sel);
    end
    checkOutput({tag, " latency"}, 128'(n), 128'(lat));
    checkOutput({tag, " data_out"}, getOut(sel), exp);
    @(negedge clk);
    checkOutput({tag, " done single cycle"}, 128'(getDone(sel)), 128'd0);
    checkOutput({tag, " busy cleared"}, 128'(getBusy(sel)), 128'd0);
    repeat (3) @(negedge clk);
    checkOutput({tag, " data_out held"}, getOut(sel), exp);
  endtask

  initial begin
    int n;
    int doneCount;
    logic seen;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    dataIn = '0;
    key0   = '0;
    key1   = '0;
    key2   = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset data_out", dout0, 128'd0);
    checkOutput("reset busy", 128'(busy0), 128'd0);
    checkOutput("reset done", 128'(done0), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, {KEY_A, 128'd0}, PT_A, CT_A, 11, "aes128 fips appendix b");
    applyStimulus(0, {KEY_B, 128'd0}, PT_B, CT_B, 11, "aes128 c.1");
    applyStimulus(1, {KEY_C, 64'd0},  PT_B, CT_C, 13, "aes192 c.2");
    applyStimulus(2, KEY_D,           PT_B, CT_D, 15, "aes256 c.3");

    // Held start with inputs changed mid-run: first result unaffected, then relaunch.
    dataIn = PT_A;
    key0   = KEY_A;
    start0 = 1'b1;
    @(negedge clk);
    checkOutput("busy test accepted", 128'(busy0), 128'd1);
    dataIn = PT_B;
    key0   = KEY_B;
    n = 0;
    seen = 1'b0;
    while (n < 16 && !seen) begin
      @(negedge clk);
      n++;
      seen = done0;
    end
    checkOutput("busy test latency", 128'(n), 128'd11);
    checkOutput("busy test result unchanged", dout0, CT_A);
    checkOutput("busy test busy low at done", 128'(busy0), 128'd0);
    @(negedge clk);
    start0 = 1'b0;
    checkOutput("held start relaunch busy", 128'(busy0), 128'd1);
    checkOutput("held start relaunch done low", 128'(done0), 128'd0);
    n = 0;
    seen = 1'b0;
    while (n < 16 && !seen) begin
      @(negedge clk);
      n++;
      seen = done0;
    end
    checkOutput("relaunch latency", 128'(n), 128'd11);
    checkOutput("relaunch result", dout0, CT_B);

    // Reset asserted after round 4 completes, while round 5 is pending.
    @(negedge clk);
    dataIn = PT_A;
    key0   = KEY_A;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre-abort busy", 128'(busy0), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort data_out cleared", dout0, 128'd0);
    checkOutput("abort busy cleared", 128'(busy0), 128'd0);
    checkOutput("abort done low", 128'(done0), 128'd0);
    checkOutput("abort aes256 data_out cleared", dout2, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done0 || busy0) doneCount++;
    end
    checkOutput("no done after abort", 128'(doneCount), 128'd0);

    // Start presented on the very first edge after reset release.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, {KEY_A, 128'd0}, PT_A, CT_A, 11, "post-reset aes128");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
